data_mem_responder: RTL
=======================

// Module: data_mem_responder
// PURPOSE
//  Data-side memory responder answering the pipeline's load/store requests (MEM stage).
//  Accepts one request via valid/ready and performs RV32I sized stores (sb/sh/sw).
//  Returns loads with byte/half/word extraction and sign/zero extension (lb/lh/lw/lbu/lhu).
//  Drives a stall line that freezes the pipeline for the wait-state latency.
// PARAMETERS
//  DEPTH_WORDS  1024   number of 32-bit words in the array (word-addressed internally)
//  LATENCY      2      wait-state cycles between accept and response (0..15)
//  ADDR_BASE    32'h0  byte address of word 0; accesses outside [BASE, BASE+4*DEPTH) fault
// PORTS
//  clk         in   1   rising-edge clock
//  rst         in   1   reset, asynchronous assert, ACTIVE-LOW (0 = reset)
//  req_valid   in   1   pipeline presents a load/store request
//  req_ready   out  1   responder can accept (high only in IDLE)
//  req_we      in   1   1 = store, 0 = load
//  req_funct3  in   3   RV32I funct3: 0=B 1=H 2=W 4=BU 5=HU
//  req_addr    in   32  byte address
//  req_wdata   in   32  store data, low bits significant for sb/sh
//  rsp_valid   out  1   one-cycle pulse: response (load data or store ack) valid
//  rsp_rdata   out  32  extended load data; 0 for stores and faults
//  rsp_err     out  1   qualifies rsp_valid: misaligned, out-of-range or illegal funct3
//  stall       out  1   combinational: hold pipeline (IF/ID, ID/EX, EX/MEM frozen)
// BEHAVIOUR
//  FSM: IDLE -> WAIT -> RESP -> IDLE.
//   - IDLE: req_ready=1. On req_valid, latch we/funct3/addr/wdata and go to WAIT (LATENCY>0)
//     or straight to RESP (LATENCY=0). The wait counter loads LATENCY-1.
//   - WAIT: req_ready=0. Decrement the counter; at 0 go to RESP.
//   - RESP: rsp_valid=1 for exactly one cycle, then IDLE. No new request is accepted in RESP.
//  Latency: rsp_valid is high LATENCY+1 cycles after the accept edge.
//  Throughput: one request per LATENCY+2 cycles.
//  stall = (IDLE & req_valid) | WAIT. Stall is low in RESP so the pipeline captures rsp_rdata.
//  Faults are checked on the latched request and take the same latency; rsp_err=1, rsp_rdata=0, no write.
//   - H/HU/sh with addr[0]!=0 faults.
//   - W/sw with addr[1:0]!=0 faults.
//   - Out-of-range address faults.
//   - funct3 3/6/7 faults; stores with funct3 4/5 fault.
//  Load extraction uses byte lane addr[1:0] (B/BU) or half lane addr[1] (H/HU).
//   - B/H sign-extend from bit 7/15; BU/HU zero-extend; W passes through.
//  Stores write only the selected byte lanes at the RESP clock edge. A request accepted
//   afterwards reads the new data; there is no forwarding inside the block.
//  req_valid outside IDLE is ignored. The latched request is stable, so input changes mid-operation have no effect.
//  Reset (rst=0, any state, async):
//   - state=IDLE, counter=0, rsp_valid=0, rsp_err=0, rsp_rdata=0.
//   - req_ready=1 once rst=1; stall follows req_valid.
//   - An in-flight store is dropped (not written). The array is NOT cleared.
//  Simultaneous rst release and req_valid: the request is accepted on the first rising edge with rst=1.
// TESTING
//  1. LATENCY=2: preload word0=0x8081_82F3; lw @0x0 -> stall high 3 cycles (accept+2 WAIT); rsp_valid on cycle 3, rdata=0x808182F3, err=0.
//  2. lb @0x3 -> 0xFFFF_FF80; lbu @0x3 -> 0x0000_0080; lh @0x2 -> 0xFFFF_8081; lhu @0x0 -> 0x0000_82F3.
//  3. sb 0xAB @0x5 then lw @0x4 (word1 init 0) -> 0x0000_AB00; sh 0x1234 @0x6 then lw @0x4 -> 0x1234_AB00.
//  4. lw @0x2, lh @0x1, sw @0x1000 (DEPTH 1024), funct3=3 -> each rsp_err=1, rdata=0, memory unchanged.
//  5. Assert rst=0 during WAIT of sw 0xDEAD_BEEF @0x8 -> outputs zero immediately; after release lw @0x8 returns the old value.
//  6. LATENCY=0, back-to-back lw requests held valid -> accept, RESP next cycle, stall pattern 1,0,1,0; req_ready 1,0,1,0.

Source files
------------

// File: rtl/data_mem_if.sv
// Pipeline <-> data memory request/response bundle.
// Master is the MEM stage, slave is the responder.
interface data_mem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        stall;

    modport master (
        output req_valid,
        output req_we,
        output req_funct3,
        output req_addr,
        output req_wdata,
        input  req_ready,
        input  rsp_valid,
        input  rsp_rdata,
        input  rsp_err,
        input  stall
    );

    modport slave (
        input  req_valid,
        input  req_we,
        input  req_funct3,
        input  req_addr,
        input  req_wdata,
        output req_ready,
        output rsp_valid,
        output rsp_rdata,
        output rsp_err,
        output stall
    );
endinterface

// File: rtl/data_mem_responder.sv
// MEM-stage data memory: sized RV32I loads/stores with fixed wait states.
// One request in flight; stall freezes the pipeline until the response.
module data_mem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] ADDR_BASE   = 32'h0
) (
    input logic        clk,
    input logic        rst,
    data_mem_if.slave  bus
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAT_M1 =
        (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic        we;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    state_t      state;
    state_t      state_nx;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nx;
    req_t        req;
    logic        accept;

    logic [31:0] off;
    logic        in_range;
    logic        misalign;
    logic        bad_f3;
    logic        fault;
    logic [AW-1:0] idx;
    logic [31:0] word;
    logic [7:0]  bsel;
    logic [15:0] hsel;
    logic [31:0] ext;
    logic [3:0]  be;
    logic [31:0] wd;

    logic [31:0] mem [DEPTH_WORDS];

    assign accept = (state == IDLE) && bus.req_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
            req   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (accept) begin
                req.we     <= bus.req_we;
                req.funct3 <= bus.req_funct3;
                req.addr   <= bus.req_addr;
                req.wdata  <= bus.req_wdata;
            end
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    if (LATENCY == 0) begin
                        state_nx = RESP;
                    end else begin
                        state_nx = WAIT;
                        cnt_nx   = LAT_M1;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_nx = RESP;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Decode the latched request; the live bus is never looked at past accept.
    always_comb begin
        off      = req.addr - ADDR_BASE;
        in_range = (req.addr >= ADDR_BASE) &&
                   ({2'b00, off[31:2]} < 32'(DEPTH_WORDS));
        idx      = off[AW+1:2];
        misalign = 1'b0;
        bad_f3   = 1'b0;
        unique case (req.funct3)
            3'd0: bad_f3 = 1'b0;
            3'd1: misalign = off[0];
            3'd2: misalign = (off[1:0] != 2'b00);
            3'd4: bad_f3 = req.we;
            3'd5: begin
                bad_f3   = req.we;
                misalign = off[0];
            end
            default: bad_f3 = 1'b1;
        endcase
        fault = !in_range || misalign || bad_f3;
    end

    always_comb begin
        word = mem[idx];
        bsel = word[{off[1:0], 3'b000} +: 8];
        hsel = off[1] ? word[31:16] : word[15:0];
        unique case (req.funct3)
            3'd0:    ext = {{24{bsel[7]}}, bsel};
            3'd1:    ext = {{16{hsel[15]}}, hsel};
            3'd4:    ext = {24'd0, bsel};
            3'd5:    ext = {16'd0, hsel};
            default: ext = word;
        endcase
    end

    // Store data is replicated across lanes so the byte enables alone pick the target.
    always_comb begin
        unique case (req.funct3[1:0])
            2'b00: begin
                be = 4'b0001 << off[1:0];
                wd = {4{req.wdata[7:0]}};
            end
            2'b01: begin
                be = off[1] ? 4'b1100 : 4'b0011;
                wd = {2{req.wdata[15:0]}};
            end
            default: begin
                be = 4'b1111;
                wd = req.wdata;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (state == RESP && req.we && !fault) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wd[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        bus.req_ready = 1'b0;
        bus.stall     = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_err   = 1'b0;
        bus.rsp_rdata = 32'd0;
        unique case (1'b1)
            (state == IDLE): begin
                bus.req_ready = 1'b1;
                bus.stall     = bus.req_valid;
            end
            (state == WAIT): begin
                bus.stall = 1'b1;
            end
            (state == RESP): begin
                bus.rsp_valid = 1'b1;
                bus.rsp_err   = fault;
                if (!fault && !req.we) begin
                    bus.rsp_rdata = ext;
                end
            end
            default: begin
                bus.req_ready = 1'b0;
            end
        endcase
    end

endmodule
